alu_writeback_stage: RTL and testbench

- Writeback stage directly downstream of the RISC-V ALU.
- Accepts ALU results tagged with a destination register through a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle into an internal 32x32 register file.
- Provides two combinational read ports with forwarding from pending entries, so the operand-fetch logic feeding the ALU always sees the architecturally newest value.

---
 rtl/alu_writeback_stage.sv | 160 ++++++++++++++++
 tb/tb_alu_writeback_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage
//
// Writeback stage that sits directly behind the ALU. Results tagged with a
// destination register are accepted through a valid/ready handshake, held in
// a small in-order FIFO, and drained one per cycle into a 32-entry register
// file. Two combinational read ports see the newest value of each register:
// the youngest pending FIFO entry wins over the register file.
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   in_valid      ALU result offered this cycle
//   in_ready      stage can accept (count < DEPTH)
//   in_rd         destination register of the offered result
//   in_result     offered ALU result (stored unmodified)
//   wb_stall      register-file write port unavailable; blocks the drain
//   rs1_addr      read port 1 index
//   rs2_addr      read port 2 index
//   rs1_data      forwarded read data, port 1
//   rs2_data      forwarded read data, port 2
//   busy          FIFO holds at least one pending result
//   retire_count  number of drained entries since reset (wraps at 2^32)
//   err_sticky    set once an ALU invalid-op marker (32'hDEADBEEF) drains
// ---------------------------------------------------------------------------
module alu_writeback_stage #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_result,
   input  logic            wb_stall,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            busy,
   output logic [31:0]     retire_count,
   output logic            err_sticky
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [XLEN-1:0] ERR_MARKER = XLEN'(32'hDEADBEEF);

   // Pending-result FIFO storage. Contents need no reset: only entries
   // inside the head..tail window (tracked by count_reg) are ever used.
   logic [4:0]      fifo_rd   [DEPTH];
   logic [XLEN-1:0] fifo_data [DEPTH];

   logic [PTR_W-1:0] head_reg;
   logic [PTR_W-1:0] tail_reg;
   logic [CNT_W-1:0] count_reg;

   // Architectural register file; cleared by reset, so it lives in flops.
   logic [XLEN-1:0] regfile_reg [NREGS];

   logic [31:0] retire_count_reg;
   logic        err_sticky_reg;

   logic            push;
   logic            pop;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;

   // in_ready is based on the registered count only, so a full FIFO never
   // accepts in the same cycle a slot frees up.
   assign in_ready  = (count_reg < CNT_W'(DEPTH));
   assign busy      = (count_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = busy && !wb_stall;
   assign head_rd   = fifo_rd[head_reg];
   assign head_data = fifo_data[head_reg];

   assign retire_count = retire_count_reg;
   assign err_sticky   = err_sticky_reg;

   // FIFO data write
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[tail_reg]   <= in_rd;
         fifo_data[tail_reg] <= in_result;
      end
   end

   // FIFO pointers, occupancy, retire bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         retire_count_reg <= '0;
         err_sticky_reg   <= 1'b0;
      end else begin
         if (push) begin
            tail_reg <= tail_reg + 1'b1;
         end
         if (pop) begin
            head_reg         <= head_reg + 1'b1;
            retire_count_reg <= retire_count_reg + 32'd1;
            if (head_data == ERR_MARKER) begin
               err_sticky_reg <= 1'b1;
            end
         end
         unique case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Register file write: x0 writes are dropped but the entry still retires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regfile_reg[r] <= '0;
         end
      end else if (pop && (head_rd != 5'd0)) begin
         regfile_reg[head_rd] <= head_data;
      end
   end

   // Read ports with forwarding. Entries are scanned oldest to youngest so
   // the last match (the tail-most one) is the value that sticks.
   logic [4:0] port_addr [2];
   assign port_addr[0] = rs1_addr;
   assign port_addr[1] = rs2_addr;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [XLEN-1:0] port_data;

         always_comb begin
            logic [PTR_W-1:0] idx;
            port_data = regfile_reg[port_addr[gi]];
            idx       = head_reg;
            for (int i = 0; i < DEPTH; i++) begin
               if ((CNT_W'(i) < count_reg) && (fifo_rd[idx] == port_addr[gi])) begin
                  port_data = fifo_data[idx];
               end
               idx = idx + 1'b1;
            end
            if (port_addr[gi] == 5'd0) begin
               port_data = '0;
            end
         end
      end
   endgenerate

   assign rs1_data = g_port[0].port_data;
   assign rs2_data = g_port[1].port_data;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback_stage
//
// Directed scenarios plus randomized traffic for alu_writeback_stage. A
// queue-based model of the pending results and an array of architectural
// registers produce every expected value.
// ---------------------------------------------------------------------------
module tb_alu_writeback_stage;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_rd;
   logic [XLEN-1:0] in_result;
   logic            wb_stall;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            busy;
   logic [31:0]     retire_count;
   logic            err_sticky;

   alu_writeback_stage #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN),
      .NREGS (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rd        (in_rd),
      .in_result    (in_result),
      .wb_stall     (wb_stall),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .busy         (busy),
      .retire_count (retire_count),
      .err_sticky   (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t      mq[$];
   logic [31:0] mregs [32];
   logic [31:0] mretire;
   bit          merr;

   int checks   = 0;
   int failures = 0;
   bit last_push;
   int cycle_no = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].rd == a) return mq[i].data;
      end
      return mregs[a];
   endfunction

   task automatic model_reset();
      mq.delete();
      for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
      mretire = 32'd0;
      merr    = 1'b0;
   endtask

   // One clock cycle: drive, check outputs against the model, advance model.
   task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] res,
                       input bit stall, input logic [4:0] a1, input logic [4:0] a2);
      bit     do_push;
      bit     do_pop;
      entry_t e;
      @(negedge clk);
      in_valid  = v;
      in_rd     = rd;
      in_result = res;
      wb_stall  = stall;
      rs1_addr  = a1;
      rs2_addr  = a2;
      #1;
      check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      check("busy", 32'(busy), 32'(mq.size() != 0));
      check("rs1_data", rs1_data, model_read(a1));
      check("rs2_data", rs2_data, model_read(a2));
      check("retire_count", retire_count, mretire);
      check("err_sticky", 32'(err_sticky), 32'(merr));
      do_push = v && (mq.size() < DEPTH);
      do_pop  = (mq.size() != 0) && !stall;
      @(posedge clk);
      cycle_no++;
      if (do_pop) begin
         e = mq.pop_front();
         mretire = mretire + 32'd1;
         if (e.rd != 5'd0) mregs[e.rd] = e.data;
         if (e.data == 32'hDEADBEEF) merr = 1'b1;
         $display("cyc %0d retire rd=%0d data=%h", cycle_no, e.rd, e.data);
      end
      if (do_push) begin
         e.rd   = rd;
         e.data = res;
         mq.push_back(e);
         $display("cyc %0d accept rd=%0d data=%h", cycle_no, rd, res);
      end
      last_push = do_push;
   endtask

   // Assert reset in the middle of a low clock phase and check that the
   // outputs clear immediately, before any clock edge.
   task automatic mid_reset(input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      in_valid = 1'b0;
      wb_stall = 1'b1;
      rs1_addr = a1;
      rs2_addr = a2;
      #2;
      reset = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_retire", retire_count, 32'd0);
      check("rst_err", 32'(err_sticky), 32'd0);
      check("rst_rs1", rs1_data, 32'd0);
      check("rst_rs2", rs2_data, 32'd0);
      model_reset();
      $display("cyc %0d reset", cycle_no);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int  k;
      bit  first_overlap;
      bit  have_offer;
      logic [4:0]  off_rd;
      logic [31:0] off_data;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_rd     = 5'd0;
      in_result = 32'd0;
      wb_stall  = 1'b0;
      rs1_addr  = 5'd1;
      rs2_addr  = 5'd2;
      model_reset();
      #1;
      check("init_busy", 32'(busy), 32'd0);
      check("init_retire", retire_count, 32'd0);
      check("init_err", 32'(err_sticky), 32'd0);
      check("init_rs1", rs1_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("init_in_ready", 32'(in_ready), 32'd1);

      // Single push drains the next cycle
      step(1, 5'd5, 32'h0000_0011, 0, 5'd5, 5'd0);
      step(0, 5'd0, 32'd0, 0, 5'd5, 5'd5);
      step(0, 5'd0, 32'd0, 0, 5'd5, 5'd0);
      #1;
      check("s1_x5", rs1_data, 32'h0000_0011);
      check("s1_retire", retire_count, 32'd1);
      check("s1_busy", 32'(busy), 32'd0);

      // Reset with a written register: it must read back as zero
      mid_reset(5'd5, 5'd5);

      // Fill while stalled; youngest forwarding on rd=3
      step(1, 5'd3, 32'hAAAA_0000, 1, 5'd3, 5'd3);
      step(1, 5'd3, 32'h5555_FFFF, 1, 5'd3, 5'd3);
      #1;
      check("s2_full_ready", 32'(in_ready), 32'd0);
      check("s2_fwd_young", rs2_data, 32'h5555_FFFF);
      step(1, 5'd4, 32'h0000_CAFE, 1, 5'd3, 5'd4);
      check("s2_held", 32'(last_push), 32'd0);
      step(1, 5'd4, 32'h0000_CAFE, 1, 5'd3, 5'd4);
      check("s2_held2", 32'(last_push), 32'd0);

      // Release stall while full with the producer still offering
      k = 0;
      first_overlap = 1'b1;
      do begin
         step(1, 5'd4, 32'h0000_CAFE, 0, 5'd3, 5'd4);
         if (k == 0) first_overlap = last_push;
         k++;
      end while (!last_push && k < 8);
      check("s3_no_slot_reuse", 32'(first_overlap), 32'd0);
      check("s3_accepted", 32'(last_push), 32'd1);
      repeat (3) step(0, 5'd0, 32'd0, 0, 5'd3, 5'd4);
      #1;
      check("s3_x3", rs1_data, 32'h5555_FFFF);
      check("s3_x4", rs2_data, 32'h0000_CAFE);
      check("s3_retire", retire_count, 32'd3);

      // Write to x0: counted, never visible
      step(1, 5'd0, 32'h1234_5678, 1, 5'd0, 5'd0);
      #1;
      check("s4_x0_pending", rs1_data, 32'd0);
      repeat (2) step(0, 5'd0, 32'd0, 0, 5'd0, 5'd3);
      #1;
      check("s4_x0_after", rs1_data, 32'd0);
      check("s4_retire", retire_count, 32'd4);

      // Invalid-op marker sets the sticky error
      step(1, 5'd7, 32'hDEAD_BEEF, 0, 5'd7, 5'd7);
      repeat (2) step(0, 5'd0, 32'd0, 0, 5'd7, 5'd7);
      #1;
      check("s5_err", 32'(err_sticky), 32'd1);
      check("s5_x7", rs1_data, 32'hDEAD_BEEF);
      step(1, 5'd7, 32'h0000_0001, 0, 5'd7, 5'd0);
      repeat (3) step(0, 5'd0, 32'd0, 0, 5'd7, 5'd0);
      #1;
      check("s5_err_sticky", 32'(err_sticky), 32'd1);

      // Reset with two entries pending
      step(1, 5'd9, 32'h0000_0099, 1, 5'd9, 5'd10);
      step(1, 5'd10, 32'h0000_00AA, 1, 5'd9, 5'd10);
      mid_reset(5'd9, 5'd7);

      // Randomized traffic; the producer holds an offer until accepted
      have_offer = 1'b0;
      off_rd     = 5'd0;
      off_data   = 32'd0;
      for (int n = 0; n < 600; n++) begin
         logic [4:0] a1;
         logic [4:0] a2;
         if (!have_offer && ($urandom_range(0, 9) < 6)) begin
            have_offer = 1'b1;
            off_rd     = 5'($urandom_range(0, 7));
            off_data   = ($urandom_range(0, 15) == 0) ? 32'hDEAD_BEEF : $urandom;
         end
         a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         a2 = 5'($urandom_range(0, 7));
         step(have_offer, off_rd, off_data, ($urandom_range(0, 2) == 0), a1, a2);
         if (last_push) have_offer = 1'b0;
         if (n == 300) mid_reset(5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
